// File: rtl/grid_pkg.sv
// Shared grid definitions: dimensions, cell codes, map colours and renderer states.
package grid_pkg;
  localparam int GRID_W = 40;
  localparam int GRID_H = 30;

  localparam logic [2:0] CELL_AIR   = 3'd0;
  localparam logic [2:0] CELL_WALL  = 3'd1;
  localparam logic [2:0] CELL_ENEMY = 3'd4;

  localparam logic [2:0] COL_BLACK  = 3'b000;
  localparam logic [2:0] COL_WHITE  = 3'b111;
  localparam logic [2:0] COL_BLUE   = 3'b001;
  localparam logic [2:0] COL_GREEN  = 3'b010;
  localparam logic [2:0] COL_RED    = 3'b100;
  localparam logic [2:0] COL_YELLOW = 3'b110;

  typedef enum logic [2:0] {
    S_WAIT,
    S_INIT,
    S_FETCH,
    S_PLOT,
    S_NEXT,
    S_DONE
  } rstate_t;
endpackage

// File: rtl/grid_renderer_if.sv
// Renderer-facing bundle: frame handshake, grid read port and VGA pixel port.
interface grid_renderer_if;
  logic       start;
  logic       done;
  logic [5:0] grid_x;
  logic [4:0] grid_y;
  logic [2:0] grid_out;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;

  modport master (
    input  start, grid_out,
    output done, grid_x, grid_y, vga_x, vga_y, vga_colour, vga_plot
  );

  modport slave (
    output start, grid_out,
    input  done, grid_x, grid_y, vga_x, vga_y, vga_colour, vga_plot
  );
endinterface

// File: rtl/grid_cell_colour.sv
// Cell code to map colour; shared with the first-person renderer.
module grid_cell_colour
  import grid_pkg::*;
(
  input  logic [2:0] code,
  output logic [2:0] colour
);
  always_comb begin
    colour = COL_YELLOW;
    case (code)
      CELL_AIR:   colour = COL_BLACK;
      CELL_WALL:  colour = COL_WHITE;
      3'd2:       colour = COL_BLUE;
      3'd3:       colour = COL_GREEN;
      CELL_ENEMY: colour = COL_RED;
      default:    colour = COL_YELLOW;
    endcase
  end
endmodule

// File: rtl/grid_renderer_datapath.sv
// Cell/pixel counters, latched cell colour and pixel address generation.
module grid_renderer_datapath
  import grid_pkg::*;
#(
  parameter int CELL_SIZE = 4,
  parameter int GW        = GRID_W,
  parameter int GH        = GRID_H
) (
  input  logic       clock,
  input  logic       reset,
  input  rstate_t    state,
  input  logic [2:0] cell_colour,
  output logic [5:0] cell_x,
  output logic [4:0] cell_y,
  output logic [2:0] colour,
  output logic       last_pix,
  output logic       last_cell,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y
);
  logic [5:0] cell_x_q, cell_x_d;
  logic [4:0] cell_y_q, cell_y_d;
  logic [3:0] pix_q, pix_d;
  logic [2:0] colour_q, colour_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cell_x_q <= '0;
      cell_y_q <= '0;
      pix_q    <= '0;
      colour_q <= '0;
    end else begin
      cell_x_q <= cell_x_d;
      cell_y_q <= cell_y_d;
      pix_q    <= pix_d;
      colour_q <= colour_d;
    end
  end

  assign last_pix  = (pix_q == 4'd15);
  assign last_cell = (cell_x_q == 6'(GW - 1)) && (cell_y_q == 5'(GH - 1));

  always_comb begin
    cell_x_d = cell_x_q;
    cell_y_d = cell_y_q;
    pix_d    = pix_q;
    colour_d = colour_q;
    case (state)
      S_INIT: begin
        cell_x_d = '0;
        cell_y_d = '0;
        pix_d    = '0;
      end
      S_FETCH: colour_d = cell_colour;
      S_PLOT:  if (!last_pix) pix_d = pix_q + 4'd1;
      S_NEXT: begin
        if (!last_cell) begin
          pix_d = '0;
          // Row-major scan: column wrap carries into the row counter.
          if (cell_x_q == 6'(GW - 1)) begin
            cell_x_d = '0;
            cell_y_d = cell_y_q + 5'd1;
          end else begin
            cell_x_d = cell_x_q + 6'd1;
          end
        end
      end
      default: ;
    endcase
  end

  assign cell_x = cell_x_q;
  assign cell_y = cell_y_q;
  assign colour = colour_q;
  assign vga_x  = 8'(cell_x_q) * 8'(CELL_SIZE) + 8'(pix_q[1:0]);
  assign vga_y  = 7'(cell_y_q) * 7'(CELL_SIZE) + 7'(pix_q[3:2]);
endmodule

// File: rtl/grid_renderer_fsm.sv
// Frame sequencer: WAIT -> INIT -> (FETCH, PLOT x16, NEXT) per cell -> DONE.
module grid_renderer_fsm
  import grid_pkg::*;
(
  input  logic    clock,
  input  logic    reset,
  input  logic    start,
  input  logic    last_pix,
  input  logic    last_cell,
  output rstate_t state
);
  rstate_t state_q, state_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_WAIT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_WAIT:  if (start) state_d = S_INIT;
      S_INIT:  state_d = S_FETCH;
      S_FETCH: state_d = S_PLOT;
      S_PLOT:  if (last_pix) state_d = S_NEXT;
      S_NEXT:  state_d = last_cell ? S_DONE : S_FETCH;
      S_DONE:  state_d = S_WAIT;
      default: state_d = S_WAIT;
    endcase
  end

  assign state = state_q;
endmodule

// File: rtl/grid_renderer.sv
// Overhead map renderer: one 4x4 VGA block per grid cell, read-only on the grid.
module grid_renderer
  import grid_pkg::*;
#(
  parameter int CELL_SIZE = 4,
  parameter int GRID_W    = grid_pkg::GRID_W,
  parameter int GRID_H    = grid_pkg::GRID_H
) (
  input logic             clock,
  input logic             reset,
  grid_renderer_if.master bus
);
  rstate_t    state;
  logic [5:0] cell_x;
  logic [4:0] cell_y;
  logic [2:0] cell_colour;
  logic [2:0] colour;
  logic       last_pix;
  logic       last_cell;

  grid_cell_colour u_colour (
    .code   (bus.grid_out),
    .colour (cell_colour)
  );

  grid_renderer_fsm u_fsm (
    .clock     (clock),
    .reset     (reset),
    .start     (bus.start),
    .last_pix  (last_pix),
    .last_cell (last_cell),
    .state     (state)
  );

  grid_renderer_datapath #(
    .CELL_SIZE (CELL_SIZE),
    .GW        (GRID_W),
    .GH        (GRID_H)
  ) u_dp (
    .clock       (clock),
    .reset       (reset),
    .state       (state),
    .cell_colour (cell_colour),
    .cell_x      (cell_x),
    .cell_y      (cell_y),
    .colour      (colour),
    .last_pix    (last_pix),
    .last_cell   (last_cell),
    .vga_x       (bus.vga_x),
    .vga_y       (bus.vga_y)
  );

  assign bus.grid_x     = cell_x;
  assign bus.grid_y     = cell_y;
  assign bus.vga_colour = colour;
  assign bus.vga_plot   = (state == S_PLOT);
  assign bus.done       = (state == S_DONE);
endmodule

// File: tb/tb_grid_renderer.sv
// Scoreboard bench for grid_renderer: expected plots queued per frame, monitor pops on vga_plot.
module tb_grid_renderer;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  grid_renderer_if bus ();

  grid_renderer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  logic [2:0] grid_mem [0:29][0:39];
  assign bus.grid_out = (bus.grid_x < 6'd40 && bus.grid_y < 5'd30) ?
                        grid_mem[bus.grid_y][bus.grid_x] : 3'd0;

  int vec_cnt = 0;
  int miss_cnt = 0;
  int cyc = 0;
  int plot_cnt = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int last_plot_cyc = 0;
  logic [17:0] exp_q [$];

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [2:0] ref_colour(input logic [2:0] code);
    case (code)
      3'd0: return 3'b000;
      3'd1: return 3'b111;
      3'd2: return 3'b001;
      3'd3: return 3'b010;
      3'd4: return 3'b100;
      default: return 3'b110;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_grid();
    for (int y = 0; y < 30; y++)
      for (int x = 0; x < 40; x++)
        grid_mem[y][x] = 3'd0;
  endtask

  task automatic push_frame();
    logic [7:0] px;
    logic [6:0] py;
    for (int cy = 0; cy < 30; cy++)
      for (int cx = 0; cx < 40; cx++)
        for (int p = 0; p < 16; p++) begin
          px = 8'(cx * 4 + (p % 4));
          py = 7'(cy * 4 + (p / 4));
          exp_q.push_back({px, py, ref_colour(grid_mem[cy][cx])});
        end
  endtask

  // Monitor: every plotted pixel must match the head of the expected queue.
  always @(negedge clock) begin
    logic [17:0] got, e;
    if (bus.vga_plot) begin
      plot_cnt++;
      last_plot_cyc = cyc;
      got = {bus.vga_x, bus.vga_y, bus.vga_colour};
      vec_cnt++;
      if (exp_q.size() == 0) begin
        miss_cnt++;
        $display("FAIL unexpected_plot: got x=%0d y=%0d c=%b expected no plot",
                 bus.vga_x, bus.vga_y, bus.vga_colour);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          miss_cnt++;
          $display("FAIL plot: got x=%0d y=%0d c=%b expected x=%0d y=%0d c=%b",
                   got[17:10], got[9:3], got[2:0], e[17:10], e[9:3], e[2:0]);
        end
      end
    end
    if (bus.done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  // Full frame from the current grid; inject > 0 re-pulses start that many cycles in.
  task automatic do_frame(input string name, input int inject);
    int d0, e, n;
    d0 = done_cnt;
    plot_cnt = 0;
    push_frame();
    @(negedge clock) bus.start = 1'b1;
    @(negedge clock) bus.start = 1'b0;
    e = cyc;
    n = 0;
    while (done_cnt == d0 && n < 30000) begin
      @(negedge clock);
      n++;
      bus.start = (n == inject);
    end
    bus.start = 1'b0;
    check({name, "_done_seen"}, int'(done_cnt != d0), 1);
    // done occupies the 21602nd cycle after the sampling edge E.
    check({name, "_done_latency"}, done_cyc - e + 1, 21602);
    check({name, "_plot_count"}, plot_cnt, 19200);
    check({name, "_queue_left"}, exp_q.size(), 0);
    check({name, "_last_plot_to_done"}, done_cyc - last_plot_cyc, 2);
    repeat (3) @(negedge clock);
    check({name, "_done_once"}, done_cnt - d0, 1);
  endtask

  initial begin
    bus.start = 1'b0;
    clear_grid();

    #1 reset = 1'b1;
    #1;
    check("reset_plot", int'(bus.vga_plot), 0);
    check("reset_done", int'(bus.done), 0);
    check("reset_outputs", int'({bus.grid_x, bus.grid_y, bus.vga_x, bus.vga_y, bus.vga_colour}), 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (100) @(negedge clock);
    check("idle_no_plot", plot_cnt, 0);
    check("idle_no_done", done_cnt, 0);

    do_frame("all_air", -1);

    clear_grid();
    grid_mem[7][5]   = 3'd4;
    grid_mem[29][39] = 3'd1;
    grid_mem[0][0]   = 3'd6;
    do_frame("mixed_midstart", 3000);

    clear_grid();
    plot_cnt = 0;
    push_frame();
    @(negedge clock) bus.start = 1'b1;
    @(negedge clock) bus.start = 1'b0;
    repeat (4999) @(negedge clock);
    // Cycle 5000 after E sits in PLOT of cell (37, 6).
    check("pre_reset_plot", int'(bus.vga_plot), 1);
    check("pre_reset_x", int'(bus.vga_x), 37 * 4 + 3);
    #2 reset = 1'b1;
    #1;
    check("mid_reset_plot", int'(bus.vga_plot), 0);
    check("mid_reset_done", int'(bus.done), 0);
    check("mid_reset_outputs", int'({bus.vga_x, bus.vga_y, bus.vga_colour}), 0);
    exp_q.delete();
    begin
      int d0;
      d0 = done_cnt;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      plot_cnt = 0;
      repeat (200) @(negedge clock);
      check("abandoned_no_done", done_cnt - d0, 0);
      check("abandoned_no_plot", plot_cnt, 0);
    end

    do_frame("after_reset", -1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end
endmodule
